count_capture: RTL and testbench
================================

Name: count_capture

Overview:
- Downstream consumer of the 8-bit event counter's `out` bus.
- On each `capture` strobe, snapshots the counter value, tags it with a wrap flag, and pushes it into a small first-word-fall-through (FWFT) FIFO.
- The FIFO drains through a valid/ready handshake to the logging/readout stage.
- Flags captures lost to a full FIFO.

Parameters:
- WIDTH, 8, width of the counter value sampled on `count_in`.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- count_in  input  WIDTH  counter value, sampled every cycle
- capture  input  1  capture strobe; one capture per high cycle
- out_data  output  WIDTH+1  bit WIDTH = wrap flag; bits WIDTH-1:0 = captured count
- out_valid  output  1  head entry available
- out_ready  input  1  consumer accepts head entry
- full  output  1  FIFO holds DEPTH entries
- empty  output  1  FIFO holds 0 entries
- level  output  clog2(DEPTH)+1  current entry count, 0..DEPTH
- overflow  output  1  sticky; a capture was dropped

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values (on any rising edge with rst=1, including mid-operation):
  - rd_ptr = wr_ptr = 0, level = 0, empty = 1, full = 0, out_valid = 0.
  - overflow = 0, prev_count = 0, wrap_pending = 0.
  - All stored entries are discarded. Storage RAM itself is not reset.
  - rst has priority over capture and pop in the same cycle.
- Wrap detection:
  - prev_count <= count_in every cycle.
  - wrap_now = (count_in < prev_count), unsigned compare.
  - Any decrease counts as a wrap, including the counter being reset.
  - wrap_pending sets on wrap_now and holds until consumed by an accepted capture.
- Capture entry value: {wrap_pending | wrap_now, count_in}, using the count_in present in the capture cycle.
- Accepted capture clears wrap_pending, unless... no exception: wrap_now in the same cycle is folded into this entry, so pending ends 0.
- Dropped capture does not clear wrap_pending; the flag carries to the next accepted capture.
- Push/pop rules:
  - pop = out_valid & out_ready.
  - push = capture & (!full | pop). When full, a simultaneous pop frees a slot and the push is accepted.
  - capture & full & !pop: entry dropped, overflow <= 1. overflow clears only on rst.
  - level <= level + push - pop.
  - full = (level == DEPTH), empty = (level == 0); both derived from the registered level.
  - Pointers wrap modulo DEPTH.
- Output:
  - FWFT: out_valid = !empty.
  - out_data = head entry when out_valid, else all zeros (masked).
  - out_data must be held stable while out_valid=1 and out_ready=0.
- Latency:
  - Capture at edge N makes the entry visible (out_valid=1) in the cycle after edge N.
  - No same-cycle bypass: capture into an empty FIFO with out_ready=1 does not pop that cycle.
- Simultaneous push and pop at 0 < level < DEPTH: level unchanged, order preserved.
- Ordering: strict FIFO.
- Structure: no state machine beyond the pointers and level counter. All outputs derive from registers, except out_data (storage read mux) and out_valid.

Test Plan:
- Reset, then count_in ramps 0..10, capture at count_in=3 and 7, out_ready=1:
  - Reads 0x003 then 0x007, each 1 cycle after its capture edge.
  - overflow=0, empty=1 afterwards.
- out_ready=0, capture on 5 consecutive cycles with count_in=10..14 (DEPTH=4):
  - full=1 and level=4 after the 4th edge; the 5th capture sets overflow=1.
  - Draining yields 0x00A, 0x00B, 0x00C, 0x00D only.
- Full FIFO, capture with out_ready=1 in the same cycle:
  - Push accepted, level stays 4, overflow stays 0.
  - Drain order is the old 3 entries, then the new value.
- count_in 254, 255, 0, 1 with capture only at 1:
  - out_data = 0x101 (wrap flag set).
  - Next capture at count_in=5 with no decrease yields 0x005.
- Wrap with the FIFO full and the capture dropped, then capture at count_in=9 after a drain:
  - out_data = 0x109 (wrap carried forward); overflow=1.
- 3 entries queued, assert rst with capture=1 and out_ready=1:
  - Next cycle level=0, empty=1, out_valid=0, out_data=0, overflow=0.
  - The capture in the reset cycle is not stored.

Source files
------------

// File: rtl/count_capture.sv
// Snapshots an event counter on each capture strobe, tags it with a wrap flag,
// and queues it in a small first-word-fall-through FIFO drained by valid/ready.
module count_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           count_in,
  input  logic                       capture,
  output logic [WIDTH:0]             out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Handshake: the head entry transfers on any cycle where out_valid and
  // out_ready are both high; while out_valid=1 and out_ready=0 the head and
  // out_data stay unchanged. out_valid never depends on out_ready.

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] prev_count;
  logic             wrap_pending;
  logic             wrap_now;
  logic             push;
  logic             pop;

  assign wrap_now  = count_in < prev_count;
  assign full      = level == LW'(DEPTH);
  assign empty     = level == '0;
  assign out_valid = !empty;
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push      = capture & (!full | pop);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overflow     <= 1'b0;
      prev_count   <= '0;
      wrap_pending <= 1'b0;
    end else begin
      prev_count <= count_in;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
      if (capture && !push) overflow <= 1'b1;
      // The entry absorbs any wrap seen now; a dropped capture keeps it pending.
      if (push)          wrap_pending <= 1'b0;
      else if (wrap_now) wrap_pending <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= {wrap_pending | wrap_now, count_in};
  end

endmodule

// File: tb/tb_count_capture.sv
// Directed plus randomized bench for count_capture, checked every cycle
// against a queue-based reference model.
module tb_count_capture;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] count_in = '0;
  logic             capture = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH:0]   out_data;
  logic             out_valid;
  logic             full;
  logic             empty;
  logic [LW-1:0]    level;
  logic             overflow;

  count_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .capture(capture),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .full(full), .empty(empty), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [WIDTH:0]   exp_q[$];
  logic [WIDTH-1:0] m_prev = '0;
  logic             m_pend = 1'b0;
  logic             m_ovf  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    check("level", 32'(level), 32'(sz));
    check("empty", 32'(empty), 32'(sz == 0));
    check("full", 32'(full), 32'(sz == DEPTH));
    check("out_valid", 32'(out_valid), 32'(sz != 0));
    check("out_data", 32'(out_data), (sz != 0) ? 32'(exp_q[0]) : 32'd0);
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Drive one cycle of inputs, advance the model over the edge, check after it.
  task automatic cycle(input logic cap, input logic [WIDTH-1:0] cnt,
                       input logic rdy, input logic r);
    logic wn;
    @(negedge clk);
    capture = cap; count_in = cnt; out_ready = rdy; rst = r;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      m_prev = '0; m_pend = 1'b0; m_ovf = 1'b0;
    end else begin
      wn = cnt < m_prev;
      if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (cap && exp_q.size() < DEPTH) begin
        exp_q.push_back({m_pend | wn, cnt});
        m_pend = 1'b0;
      end else begin
        if (cap) m_ovf = 1'b1;
        m_pend = m_pend | wn;
      end
      m_prev = cnt;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    logic [WIDTH-1:0] c;
    logic             cap, rdy, r;
    int               rdy_pct;

    // reset state
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_level", 32'(level), 32'd0);

    // ramp with two captures, consumer always ready
    for (int i = 0; i <= 10; i++) begin
      cycle(i == 3 || i == 7, 8'(i), 1'b1, 1'b0);
      if (i == 3) check("ramp_cap3", 32'(out_data), 32'h003);
      if (i == 7) check("ramp_cap7", 32'(out_data), 32'h007);
    end
    check("ramp_empty", 32'(empty), 32'd1);
    check("ramp_ovf", 32'(overflow), 32'd0);

    // fill past full with consumer stalled
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'(10 + i), 1'b0, 1'b0);
      if (i == 3) begin
        check("fill_full", 32'(full), 32'd1);
        check("fill_level", 32'(level), 32'd4);
        check("fill_ovf0", 32'(overflow), 32'd0);
      end
    end
    check("fill_ovf1", 32'(overflow), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("fill_drain", 32'(out_data), 32'(10 + k));
      cycle(1'b0, 8'd14, 1'b1, 1'b0);
    end
    check("fill_drained", 32'(empty), 32'd1);

    // full FIFO accepts a capture alongside a pop
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(20 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'd24, 1'b1, 1'b0);
    check("fullpop_level", 32'(level), 32'd4);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("fullpop_drain", 32'(out_data), 32'(21 + k));
      cycle(1'b0, 8'd25, 1'b1, 1'b0);
    end

    // counter wrap tags the next capture only
    cycle(1'b0, 8'd254, 1'b0, 1'b0);
    cycle(1'b0, 8'd255, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b0);
    cycle(1'b1, 8'd1, 1'b0, 1'b0);
    check("wrap_tag", 32'(out_data), 32'h101);
    cycle(1'b0, 8'd2, 1'b1, 1'b0);
    cycle(1'b1, 8'd5, 1'b0, 1'b0);
    check("wrap_clear", 32'(out_data), 32'h005);
    cycle(1'b0, 8'd6, 1'b1, 1'b0);

    // wrap seen on a dropped capture carries forward
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(30 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'd2, 1'b0, 1'b0);
    check("drop_ovf", 32'(overflow), 32'd1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 8'(3 + k), 1'b1, 1'b0);
    cycle(1'b1, 8'd9, 1'b0, 1'b0);
    check("carry_tag", 32'(out_data), 32'h109);
    check("carry_ovf", 32'(overflow), 32'd1);
    cycle(1'b0, 8'd10, 1'b1, 1'b0);

    // reset wins over capture and pop
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(11 + i), 1'b0, 1'b0);
    check("pre_rst_level", 32'(level), 32'd3);
    cycle(1'b1, 8'd20, 1'b1, 1'b1);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    cycle(1'b0, 8'd21, 1'b0, 1'b0);
    check("mid_rst_nostore", 32'(empty), 32'd1);

    // randomized traffic with varying back-pressure
    c = 8'd21;
    for (int i = 0; i < 3000; i++) begin
      rdy_pct = ((i / 300) % 2 == 0) ? 80 : 25;
      if ($urandom_range(0, 15) == 0) c = 8'($urandom);
      else c = c + 8'd1;
      cap = $urandom_range(0, 2) == 0;
      rdy = $urandom_range(1, 100) <= rdy_pct;
      r   = $urandom_range(0, 299) == 0;
      cycle(cap, c, rdy, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
